// File: rtl/frame_sched_pkg.sv
// frame_sched_pkg: register map, CTRL bit indices and STATUS field layout shared by the frame page scheduler
package frame_sched_pkg;
  localparam int ADDR_CTRL = 16;
  localparam int ADDR_HOLD = 17;
  localparam int ADDR_CFG = 18;
  localparam int ADDR_STATUS = 19;
  localparam int CTRL_EN = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_SWAP = 2;
  localparam int STAT_FRONT = 0;
  localparam int STAT_SWAP = 1;
  localparam int STAT_CNT_LSB = 2;
  localparam int STAT_CNT_W = 6;
endpackage

// File: rtl/frame_page_scheduler_if.sv
// frame_page_scheduler_if: register write/read bus from the SPI slave
//   wr_en/wr_addr/wr_data: single-cycle write strobe; rd_addr/rd_data: combinational read
interface frame_page_scheduler_if #(parameter int ADDR_W = 5) ();
  logic wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0] wr_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0] rd_data;
  modport master(output wr_en, wr_addr, wr_data, rd_addr, input rd_data);
  modport slave(input wr_en, wr_addr, wr_data, rd_addr, output rd_data);
endinterface

// File: rtl/frame_page_store.sv
// frame_page_store: two pages of FRAME_BYTES byte registers with one write port
//   we/page/idx/data: write port; page0/page1: flattened pages, byte k at [8k+7:8k]
module frame_page_store #(parameter int FRAME_BYTES = 8) (
  input  logic clk,
  input  logic rst_n,
  input  logic we,
  input  logic page,
  input  logic [$clog2(FRAME_BYTES)-1:0] idx,
  input  logic [7:0] data,
  output logic [8*FRAME_BYTES-1:0] page0,
  output logic [8*FRAME_BYTES-1:0] page1
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      page0 <= '0;
      page1 <= '0;
    end else if (we) begin
      if (!page) page0[idx*8 +: 8] <= data;
      if (page) page1[idx*8 +: 8] <= data;
    end
endmodule

// File: rtl/frame_page_scheduler.sv
// frame_page_scheduler: double-buffered frame store with tear-free page flips on frame_done
//   bus: register write/read port; frame_done: end-of-frame pulse from the LED driver
//   frame_buffer: displayed page (0 when disabled); frame_cfg: CFG[5:0]; page_flipped: pulse after a flip
module frame_page_scheduler import frame_sched_pkg::*; #(
  parameter int FRAME_BYTES = 8,
  parameter int ADDR_W = 5,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  frame_page_scheduler_if.slave bus,
  input  logic frame_done,
  output logic [8*FRAME_BYTES-1:0] frame_buffer,
  output logic [5:0] frame_cfg,
  output logic page_flipped
);
  localparam int IDX_W = $clog2(FRAME_BYTES);
  logic front, swap_pending, en, auto_m;
  logic [7:0] hold, cfg, hold_thr, ctrl_rd, status;
  logic [CNT_W-1:0] hold_cnt, frame_cnt;
  logic [8*FRAME_BYTES-1:0] page0, page1, rd_vec;
  logic wr_page, wr_front_half, rd_page, rd_front_half, ctrl_wr, ev, flip, auto_clear, unused_ok;
  assign wr_page = bus.wr_en && bus.wr_addr < ADDR_W'(2*FRAME_BYTES);
  assign wr_front_half = bus.wr_addr >= ADDR_W'(FRAME_BYTES);
  assign rd_page = bus.rd_addr < ADDR_W'(2*FRAME_BYTES);
  assign rd_front_half = bus.rd_addr >= ADDR_W'(FRAME_BYTES);
  assign ctrl_wr = bus.wr_en && bus.wr_addr == ADDR_W'(ADDR_CTRL);
  assign auto_clear = ctrl_wr && auto_m && !bus.wr_data[CTRL_AUTO];
  assign hold_thr = (hold == 8'd0) ? 8'd0 : hold - 8'd1;
  assign ev = frame_done && en;
  // swap_pending is the registered value, so a swap_req arriving with this event waits for the next one
  assign flip = ev && (swap_pending || (auto_m && hold_cnt >= CNT_W'(hold_thr)));
  assign frame_cfg = cfg[5:0];
  assign unused_ok = &{1'b0, frame_cnt};
  // back-page writes decode against the pre-edge front_page, so a coincident flip displays them
  frame_page_store #(.FRAME_BYTES(FRAME_BYTES)) u_store (
    .clk(clk),
    .rst_n(rst_n),
    .we(wr_page),
    .page(wr_front_half ? front : !front),
    .idx(bus.wr_addr[IDX_W-1:0]),
    .data(bus.wr_data),
    .page0(page0),
    .page1(page1)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      en <= 1'b0;
      auto_m <= 1'b0;
      hold <= '0;
      cfg <= '0;
      front <= 1'b0;
      swap_pending <= 1'b0;
      hold_cnt <= '0;
      frame_cnt <= '0;
      page_flipped <= 1'b0;
    end else begin
      if (ctrl_wr) {auto_m, en} <= {bus.wr_data[CTRL_AUTO], bus.wr_data[CTRL_EN]};
      if (bus.wr_en && bus.wr_addr == ADDR_W'(ADDR_HOLD)) hold <= bus.wr_data;
      if (bus.wr_en && bus.wr_addr == ADDR_W'(ADDR_CFG)) cfg <= bus.wr_data;
      swap_pending <= (ctrl_wr && bus.wr_data[CTRL_SWAP]) ? 1'b1 : flip ? 1'b0 : swap_pending;
      front <= front ^ flip;
      hold_cnt <= (flip || auto_clear) ? '0 : ev ? hold_cnt + 1'b1 : hold_cnt;
      frame_cnt <= frame_cnt + CNT_W'(ev);
      page_flipped <= flip;
    end
  always_comb begin
    frame_buffer = en ? (front ? page1 : page0) : '0;
    rd_vec = (rd_front_half ? front : !front) ? page1 : page0;
    ctrl_rd = '0;
    ctrl_rd[CTRL_EN] = en;
    ctrl_rd[CTRL_AUTO] = auto_m;
    status = '0;
    status[STAT_FRONT] = front;
    status[STAT_SWAP] = swap_pending;
    status[STAT_CNT_LSB +: STAT_CNT_W] = frame_cnt[STAT_CNT_W-1:0];
    bus.rd_data = rd_page ? rd_vec[bus.rd_addr[IDX_W-1:0]*8 +: 8] :
                  bus.rd_addr == ADDR_W'(ADDR_CTRL) ? ctrl_rd :
                  bus.rd_addr == ADDR_W'(ADDR_HOLD) ? hold :
                  bus.rd_addr == ADDR_W'(ADDR_CFG) ? cfg :
                  bus.rd_addr == ADDR_W'(ADDR_STATUS) ? status : 8'd0;
  end
endmodule

// File: tb/tb_frame_page_scheduler.sv
// tb_frame_page_scheduler: table vectors, corner sequences and randomized model check of frame_page_scheduler
module tb_frame_page_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_done = 1'b0;
  logic [63:0] frame_buffer;
  logic [5:0] frame_cfg;
  logic page_flipped;
  int checks = 0;
  int errors = 0;
  frame_page_scheduler_if #(.ADDR_W(5)) bus();
  frame_page_scheduler #(.FRAME_BYTES(8), .ADDR_W(5), .CNT_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .frame_done(frame_done),
    .frame_buffer(frame_buffer),
    .frame_cfg(frame_cfg),
    .page_flipped(page_flipped)
  );
  always #5 clk = ~clk;
  logic [7:0] m_page [2][8];
  bit m_front, m_pend, m_en, m_auto, m_flipped;
  logic [7:0] m_hold, m_cfg;
  int m_hcnt, m_fcnt;
  function automatic void m_reset();
    for (int p = 0; p < 2; p++) for (int k = 0; k < 8; k++) m_page[p][k] = 8'h00;
    m_front = 0; m_pend = 0; m_en = 0; m_auto = 0; m_flipped = 0;
    m_hold = 0; m_cfg = 0; m_hcnt = 0; m_fcnt = 0;
  endfunction
  function automatic void m_step(bit we, int a, logic [7:0] d, bit fd);
    bit ev = fd && m_en;
    int thr = ((m_hold == 0) ? 1 : int'(m_hold)) - 1;
    bit flip = ev && (m_pend || (m_auto && m_hcnt >= thr));
    bit was_auto = m_auto;
    if (we && a < 8) m_page[!m_front][a] = d;
    if (we && a >= 8 && a < 16) m_page[m_front][a-8] = d;
    if (flip) begin
      m_front = !m_front; m_pend = 0; m_hcnt = 0;
    end else if (ev) m_hcnt = (m_hcnt + 1) % 256;
    if (ev) m_fcnt = (m_fcnt + 1) % 256;
    if (we && a == 16) begin
      m_en = d[0]; m_auto = d[1];
      if (d[2]) m_pend = 1;
      if (was_auto && !d[1]) m_hcnt = 0;
    end
    if (we && a == 17) m_hold = d;
    if (we && a == 18) m_cfg = d;
    m_flipped = flip;
  endfunction
  function automatic logic [7:0] m_rd(int a);
    if (a < 8) return m_page[!m_front][a];
    if (a < 16) return m_page[m_front][a-8];
    if (a == 16) return {6'd0, m_auto, m_en};
    if (a == 17) return m_hold;
    if (a == 18) return m_cfg;
    if (a == 19) return {6'(m_fcnt % 64), m_pend, m_front};
    return 8'h00;
  endfunction
  function automatic logic [63:0] m_fb();
    logic [63:0] fb = '0;
    if (m_en) for (int k = 0; k < 8; k++) fb[8*k +: 8] = m_page[m_front][k];
    return fb;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick(input logic we, input logic [4:0] a, input logic [7:0] d, input logic fd);
    bus.wr_en = we; bus.wr_addr = a; bus.wr_data = d; frame_done = fd;
    @(posedge clk); #1;
    m_step(we, int'(a), d, fd);
    bus.wr_en = 1'b0; frame_done = 1'b0;
  endtask
  task automatic do_reset();
    bus.wr_en = 1'b0; frame_done = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_reset();
  endtask
  task automatic rd_chk(input string nm, input logic [4:0] a, input logic [7:0] exp);
    bus.rd_addr = a; #1;
    chk(nm, 64'(bus.rd_data), 64'(exp));
  endtask
  typedef struct {
    bit rst; bit we; logic [4:0] a; logic [7:0] d; bit fd;
    logic [4:0] ra; logic [7:0] erd; bit efl; logic [7:0] efb; logic [5:0] ecfg;
  } vec_t;
  vec_t vt[$];
  task automatic add(input bit rst, input bit we, input logic [4:0] a, input logic [7:0] d, input bit fd,
                     input logic [4:0] ra, input logic [7:0] erd, input bit efl, input logic [7:0] efb, input logic [5:0] ecfg);
    vt.push_back('{rst: rst, we: we, a: a, d: d, fd: fd, ra: ra, erd: erd, efl: efl, efb: efb, ecfg: ecfg});
  endtask
  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_reset();
    for (int a = 0; a < 32; a++) rd_chk("reset_rd", 5'(a), 8'h00);
    chk("reset_fb", frame_buffer, 64'h0);
    chk("reset_cfg", 64'(frame_cfg), 64'h0);
    chk("reset_flipped", 64'(page_flipped), 64'h0);
    add(1, 0, 0, 8'h00, 0, 19, 8'h00, 0, 8'h00, 0);
    add(0, 1, 0, 8'hA5, 0, 8, 8'h00, 0, 8'h00, 0);
    add(0, 0, 0, 8'h00, 0, 0, 8'hA5, 0, 8'h00, 0);
    add(0, 1, 16, 8'h05, 0, 19, 8'h02, 0, 8'h00, 0);
    add(0, 0, 0, 8'h00, 1, 19, 8'h05, 1, 8'hA5, 0);
    add(0, 0, 0, 8'h00, 0, 19, 8'h05, 0, 8'hA5, 0);
    add(0, 0, 0, 8'h00, 0, 8, 8'hA5, 0, 8'hA5, 0);
    add(1, 1, 17, 8'h03, 0, 17, 8'h03, 0, 8'h00, 0);
    add(0, 1, 16, 8'h03, 0, 16, 8'h03, 0, 8'h00, 0);
    add(0, 0, 0, 8'h00, 1, 19, 8'h04, 0, 8'h00, 0);
    add(0, 0, 0, 8'h00, 1, 19, 8'h08, 0, 8'h00, 0);
    add(0, 0, 0, 8'h00, 1, 19, 8'h0D, 1, 8'h00, 0);
    add(0, 0, 0, 8'h00, 1, 19, 8'h11, 0, 8'h00, 0);
    add(0, 0, 0, 8'h00, 1, 19, 8'h15, 0, 8'h00, 0);
    add(0, 0, 0, 8'h00, 1, 19, 8'h18, 1, 8'h00, 0);
    add(0, 0, 0, 8'h00, 1, 19, 8'h1C, 0, 8'h00, 0);
    add(1, 1, 16, 8'h05, 0, 19, 8'h02, 0, 8'h00, 0);
    add(0, 1, 16, 8'h00, 0, 19, 8'h02, 0, 8'h00, 0);
    add(0, 0, 0, 8'h00, 1, 19, 8'h02, 0, 8'h00, 0);
    add(0, 0, 0, 8'h00, 1, 19, 8'h02, 0, 8'h00, 0);
    add(0, 1, 16, 8'h01, 0, 19, 8'h02, 0, 8'h00, 0);
    add(0, 0, 0, 8'h00, 1, 19, 8'h05, 1, 8'h00, 0);
    add(1, 1, 16, 8'h01, 0, 19, 8'h00, 0, 8'h00, 0);
    add(0, 1, 16, 8'h05, 1, 19, 8'h06, 0, 8'h00, 0);
    add(0, 0, 0, 8'h00, 1, 19, 8'h09, 1, 8'h00, 0);
    add(1, 1, 17, 8'h00, 0, 17, 8'h00, 0, 8'h00, 0);
    add(0, 1, 16, 8'h03, 0, 16, 8'h03, 0, 8'h00, 0);
    add(0, 0, 0, 8'h00, 1, 19, 8'h05, 1, 8'h00, 0);
    add(0, 0, 0, 8'h00, 1, 19, 8'h08, 1, 8'h00, 0);
    add(0, 1, 25, 8'hFF, 0, 25, 8'h00, 0, 8'h00, 0);
    add(0, 1, 19, 8'hFF, 0, 19, 8'h08, 0, 8'h00, 0);
    add(0, 1, 18, 8'h7F, 0, 18, 8'h7F, 0, 8'h00, 6'h3F);
    add(0, 1, 9, 8'h5A, 0, 9, 8'h5A, 0, 8'h00, 6'h3F);
    add(1, 1, 17, 8'h0A, 0, 17, 8'h0A, 0, 8'h00, 0);
    add(0, 1, 16, 8'h03, 0, 16, 8'h03, 0, 8'h00, 0);
    add(0, 0, 0, 8'h00, 1, 19, 8'h04, 0, 8'h00, 0);
    add(0, 0, 0, 8'h00, 1, 19, 8'h08, 0, 8'h00, 0);
    add(0, 0, 0, 8'h00, 1, 19, 8'h0C, 0, 8'h00, 0);
    add(0, 1, 17, 8'h02, 0, 17, 8'h02, 0, 8'h00, 0);
    add(0, 0, 0, 8'h00, 1, 19, 8'h11, 1, 8'h00, 0);
    foreach (vt[i]) begin
      if (vt[i].rst) do_reset();
      tick(vt[i].we, vt[i].a, vt[i].d, vt[i].fd);
      rd_chk($sformatf("vec%0d_rd", i), vt[i].ra, vt[i].erd);
      chk($sformatf("vec%0d_flipped", i), 64'(page_flipped), 64'(vt[i].efl));
      chk($sformatf("vec%0d_fb", i), 64'(frame_buffer[7:0]), 64'(vt[i].efb));
      chk($sformatf("vec%0d_cfg", i), 64'(frame_cfg), 64'(vt[i].ecfg));
    end
    do_reset();
    tick(1, 17, 8'h05, 0);
    tick(1, 3, 8'h3C, 0);
    tick(1, 18, 8'h2A, 0);
    tick(1, 16, 8'h07, 0);
    tick(0, 0, 8'h00, 1);
    chk("arst_pre_flip", 64'(page_flipped), 64'h1);
    tick(0, 0, 8'h00, 1);
    rd_chk("arst_pre_status", 19, 8'h09);
    chk("arst_pre_fb", frame_buffer, 64'h0000_0000_3C00_0000);
    chk("arst_pre_cfg", 64'(frame_cfg), 64'h2A);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_fb", frame_buffer, 64'h0);
    chk("arst_cfg", 64'(frame_cfg), 64'h0);
    chk("arst_flipped", 64'(page_flipped), 64'h0);
    chk("arst_status", 64'(bus.rd_data), 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_reset();
    tick(0, 0, 8'h00, 1);
    chk("arst_post_flipped", 64'(page_flipped), 64'h0);
    rd_chk("arst_post_status", 19, 8'h00);
    do_reset();
    for (int n = 0; n < 400; n++) begin
      int a, d;
      a = ($urandom_range(0, 9) < 4) ? $urandom_range(16, 18) : $urandom_range(0, 31);
      d = $urandom_range(0, 255);
      if (a == 17) d = $urandom_range(0, 4);
      if (a == 16) d = $urandom_range(0, 7) | (($urandom_range(0, 3) != 0) ? 1 : 0);
      tick($urandom_range(0, 1) == 1, 5'(a), 8'(d), $urandom_range(0, 9) < 3);
      a = $urandom_range(0, 31);
      rd_chk("rand_rd", 5'(a), m_rd(a));
      chk("rand_fb", frame_buffer, m_fb());
      chk("rand_cfg", 64'(frame_cfg), 64'(m_cfg[5:0]));
      chk("rand_flipped", 64'(page_flipped), 64'(m_flipped));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/frame_page_scheduler.md
Name: frame_page_scheduler

Overview:
- Double-buffered frame store and page-flip controller between the SPI register interface and the charlieplex LED driver.
- Holds two 8-byte frame pages plus control registers, and presents the displayed page as a flattened 64-bit bus.
- Swaps pages only on the driver's frame-done pulse, so frames never tear; supports manual flips and timed auto-flip animation.

Parameters:
- FRAME_BYTES, 8, bytes per page; frame_buffer width is 8*FRAME_BYTES.
- ADDR_W, 5, register address width.
- CNT_W, 8, width of the frame counter and hold counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  single-cycle write strobe from the SPI slave
- wr_addr  in  ADDR_W  write address
- wr_data  in  8  write data
- rd_addr  in  ADDR_W  read address
- rd_data  out  8  combinational read data
- frame_done  in  1  one-cycle pulse from the charlie driver at end of frame
- frame_buffer  out  8*FRAME_BYTES  displayed page; byte k at bits [8k+7:8k]
- frame_cfg  out  6  driver configuration (CFG[5:0])
- page_flipped  out  1  one-cycle pulse, registered, in the cycle after a flip

Behaviour:
- Address map:
  - 0-7: back page (the page not displayed).
  - 8-15: front page (displayed; direct write, may tear).
  - 16 CTRL: bit0 enable, bit1 auto, bit2 swap_req (write-1 sets swap_pending; reads 0).
  - 17 HOLD: frames per page in auto mode; 0 is treated as 1.
  - 18 CFG.
  - 19 STATUS (read-only): bit0 front_page, bit1 swap_pending, bits7:2 frame_cnt[5:0].
  - 20-31: writes ignored, reads 0. Writes to STATUS are ignored.
- Page decode uses front_page as registered before the current edge. A back-page write in the same cycle as a flip lands in the pre-flip back page, which becomes displayed.
- frame_buffer = enable ? page[front_page] : 0. It is a combinational mux of registers; a write is visible the cycle after wr_en.
- frame_cfg = CFG[5:0], registered.
- Effective frame event: frame_done && enable. frame_done is ignored when enable=0; swap_pending is retained.
- On each effective event:
  - frame_cnt increments and wraps 255->0.
  - hold_cnt increments unless a flip occurs.
- A flip occurs on an effective event if swap_pending is set, or if auto=1 and hold_cnt >= max(HOLD,1)-1.
- On a flip:
  - front_page toggles.
  - hold_cnt clears to 0.
  - swap_pending clears.
  - page_flipped pulses the next cycle.
- Simultaneous manual and auto flip conditions produce a single toggle.
- A CTRL write setting swap_req in the same cycle as an effective event sets swap_pending, but the flip waits for the next event; the current event does not flip for it. Auto-flip still evaluates normally on that event.
- A HOLD write takes effect at the next event comparison. If hold_cnt already meets or exceeds the new threshold, the next event flips.
- Clearing auto clears hold_cnt.
- Reset (asynchronous, any time, including mid-frame) clears:
  - all pages, CTRL, HOLD, CFG;
  - front_page, swap_pending, hold_cnt, frame_cnt;
  - page_flipped = 0, frame_buffer = 0, frame_cfg = 0.

Decomposition:
- Shared package frame_sched_pkg holds:
  - register address constants (ADDR_CTRL=16, ADDR_HOLD=17, ADDR_CFG=18, ADDR_STATUS=19);
  - CTRL bit indices (CTRL_EN=0, CTRL_AUTO=1, CTRL_SWAP=2);
  - STATUS field positions.
- One sub-module, frame_page_store: a 2xFRAME_BYTES byte register array with one write port (page, byte, data) and two flattened page outputs. Flip/counter logic stays in the top of this block.

Test Plan:
- Reset then read all addresses -> rd_data=0 everywhere; frame_buffer=0; frame_cfg=0.
- Write back-page byte0=0xA5, CTRL=0x05, then pulse frame_done -> front_page=1, frame_buffer[7:0]=0xA5, page_flipped high for one cycle, STATUS=0x05 (frame_cnt=1, front_page=1).
- CTRL=0x03, HOLD=3, issue 7 frame_done pulses -> flips after pulses 3 and 6 only; front_page=0 at end; frame_cnt=7.
- CTRL=0x00 with swap_req set earlier, pulse frame_done twice -> no flip, frame_cnt unchanged, STATUS bit1=1; then set enable and pulse once -> single flip.
- CTRL write with swap_req coincident with frame_done -> no flip that cycle, STATUS bit1=1; next frame_done -> flip.
- Assert rst_n low mid-run with front_page=1, auto on, and hold_cnt nonzero -> all outputs 0 immediately without waiting for a clock edge; after release, the first frame_done produces no flip.
